// File: rtl/binary_to_bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   bcd_state_t    : controller states (IDLE, SHIFT, DONE)
//   BCD_ADJ_THRESH : digit value at which the double-dabble +3 correction fires
//   BCD_ADJ_ADD    : correction added to a digit before each shift
//   XS3_BIAS       : excess-3 bias used for the optional xs3 output
//   min_digits()   : decimal digits needed to hold the largest WIDTH-bit value
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
    localparam logic [3:0] XS3_BIAS       = 4'd3;

    // Counts decimal digits of 2^width-1, i.e. ceil(width*log10(2)).
    function automatic int min_digits(input int width);
        int max_v;
        int d;
        max_v = (1 << width) - 1;
        d     = 0;
        for (int i = 0; i < 10; i++) begin
            if (max_v > 0) begin
                d     = d + 1;
                max_v = max_v / 10;
            end
        end
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq_if
// Request/result bundle between a requester and the BCD converter.
//   start, bin          : request pulse and operand (requester -> converter)
//   busy, done, bcd     : status and packed BCD result (converter -> requester)
//   xs3                 : excess-3 digits, only when BCD_XS3_OUT_EN is defined
// Modports: master (requester side), slave (converter side).
// ---------------------------------------------------------------------------
interface binary_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BCD_XS3_OUT_EN
    logic [4*DIGITS-1:0]   xs3;

    modport master (output start, output bin,
                    input  busy,  input  done, input bcd, input xs3);
    modport slave  (input  start, input  bin,
                    output busy,  output done, output bcd, output xs3);
`else
    modport master (output start, output bin,
                    input  busy,  input  done, input bcd);
    modport slave  (input  start, input  bin,
                    output busy,  output done, output bcd);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble digit correction: adds 3 to a 4-bit digit that is >= 5, so
// the following left shift carries correctly into the next decimal digit.
//   din  : digit before correction
//   dout : corrected digit (4-bit wrap, never reached for legal inputs)
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;
endmodule

// File: rtl/binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq
// Sequential double-dabble converter: one shift per clock, WIDTH shifts per
// conversion, result registered in a DONE cycle with a one-cycle done pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of binary_to_bcd_seq_if (start/bin in, busy/done/bcd out)
// Optional macro BCD_XS3_OUT_EN adds the registered excess-3 output bus.xs3.
//
//   state | meaning
//   IDLE  | waiting for start; operand captured on the accepting edge
//   SHIFT | adjust digits then shift {acc,bin_sh}; WIDTH cycles
//   DONE  | copy acc to bcd, pulse done, return to IDLE
// ---------------------------------------------------------------------------
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    binary_to_bcd_seq_if.slave   bus
);
    localparam int NB    = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "binary_to_bcd_seq: WIDTH %0d outside 4..16", WIDTH);
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $fatal(1, "binary_to_bcd_seq: DIGITS %0d too small for WIDTH %0d", DIGITS, WIDTH);
    end

    bcd_state_t         state_q, state_d;
    logic [WIDTH-1:0]   bin_sh_q, bin_sh_d;
    logic [NB-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NB-1:0]      bcd_q, bcd_d;

    logic [NB-1:0]      acc_adj;
    logic [NB+WIDTH-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

    // Adjusted digits and remaining operand bits shift as one register.
    assign shifted = {acc_adj, bin_sh_q} << 1;

`ifdef BCD_XS3_OUT_EN
    logic [NB-1:0] xs3_q, xs3_d;
    logic [NB-1:0] acc_xs3;

    for (genvar g = 0; g < DIGITS; g++) begin : g_xs3
        assign acc_xs3[4*g +: 4] = acc_q[4*g +: 4] + XS3_BIAS;
    end
`endif

    always_comb begin
        state_d  = state_q;
        bin_sh_d = bin_sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        done_d   = 1'b0;
`ifdef BCD_XS3_OUT_EN
        xs3_d    = xs3_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SHIFT;
                    bin_sh_d = bus.bin;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH - 1);
                end
            end
            SHIFT: begin
                acc_d    = shifted[NB+WIDTH-1:WIDTH];
                bin_sh_d = shifted[WIDTH-1:0];
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                bcd_d   = acc_q;
`ifdef BCD_XS3_OUT_EN
                xs3_d   = acc_xs3;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bin_sh_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
`ifdef BCD_XS3_OUT_EN
            xs3_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bin_sh_q <= bin_sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bcd_q    <= bcd_d;
`ifdef BCD_XS3_OUT_EN
            xs3_q    <= xs3_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
`ifdef BCD_XS3_OUT_EN
    assign bus.xs3  = xs3_q;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_binary_to_bcd_seq
// Scoreboard bench for binary_to_bcd_seq at WIDTH=8/DIGITS=3 and
// WIDTH=4/DIGITS=2. Drivers push {operand, accept time}; monitors pop on
// done and compare against decimal digits computed by division.
// ---------------------------------------------------------------------------
module tb_binary_to_bcd_seq;
    localparam int W1 = 8;
    localparam int D1 = 3;
    localparam int W2 = 4;
    localparam int D2 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    binary_to_bcd_seq_if #(.WIDTH(W1), .DIGITS(D1)) bus1 ();
    binary_to_bcd_seq_if #(.WIDTH(W2), .DIGITS(D2)) bus2 ();

    binary_to_bcd_seq #(.WIDTH(W1), .DIGITS(D1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    binary_to_bcd_seq #(.WIDTH(W2), .DIGITS(D2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        int v;
        int t;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];
    exp_t e1, e2;
    int   last1 = 0;

    int errors = 0;
    int checks = 0;

    function automatic int ref_bcd(input int v, input int nd);
        int r = 0;
        int p = 1;
        for (int i = 0; i < nd; i++) begin
            r = r | (((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int ref_xs3(input int v, input int nd);
        int r = 0;
        int p = 1;
        for (int i = 0; i < nd; i++) begin
            r = r | ((((v / p) % 10) + 3) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (bus1.done === 1'b1) begin
            if (sb1.size() == 0) begin
                check("dut1_spurious_done", 32'd1, 32'd0);
            end else begin
                e1 = sb1.pop_front();
                check("dut1_bcd", 32'(bus1.bcd), ref_bcd(e1.v, D1));
                check("dut1_done_latency", cyc, e1.t + W1 + 1);
                for (int i = 0; i < D1; i++)
                    check("dut1_digit_le9", 32'(bus1.bcd[4*i +: 4] > 4'd9), 32'd0);
`ifdef BCD_XS3_OUT_EN
                check("dut1_xs3", 32'(bus1.xs3), ref_xs3(e1.v, D1));
`endif
                last1 = ref_bcd(e1.v, D1);
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.done === 1'b1) begin
            if (sb2.size() == 0) begin
                check("dut2_spurious_done", 32'd1, 32'd0);
            end else begin
                e2 = sb2.pop_front();
                check("dut2_bcd", 32'(bus2.bcd), ref_bcd(e2.v, D2));
                check("dut2_done_latency", cyc, e2.t + W2 + 1);
                for (int i = 0; i < D2; i++)
                    check("dut2_digit_le9", 32'(bus2.bcd[4*i +: 4] > 4'd9), 32'd0);
`ifdef BCD_XS3_OUT_EN
                check("dut2_xs3", 32'(bus2.xs3), ref_xs3(e2.v, D2));
`endif
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic accept1(input int v);
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.bin   = W1'(v);
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus1.bin   = W1'($urandom);
        sb1.push_back('{v: v, t: cyc});
    endtask

    // Accept, then consume exactly the cycles until the earliest next accept.
    task automatic run1(input int v, input bit chk_busy);
        accept1(v);
        for (int i = 0; i < W1; i++) begin
            @(negedge clk);
            if (chk_busy) check("dut1_busy_high", 32'(bus1.busy), 32'd1);
            if (chk_busy && i == 0) check("dut1_bcd_hold", 32'(bus1.bcd), last1);
        end
        @(negedge clk);
        if (chk_busy) begin
            check("dut1_busy_low", 32'(bus1.busy), 32'd0);
            check("dut1_done_low", 32'(bus1.done), 32'd0);
        end
    endtask

    task automatic accept2(input int v);
        @(negedge clk);
        bus2.start = 1'b1;
        bus2.bin   = W2'(v);
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        bus2.bin   = W2'($urandom);
        sb2.push_back('{v: v, t: cyc});
    endtask

    task automatic seq1();
        int v;
        run1(255, 1'b1);
        run1(0, 1'b1);
        run1(99, 1'b1);
        repeat (2) @(negedge clk);

        // start during SHIFT must be dropped
        accept1(42);
        repeat (2) @(negedge clk);
        bus1.start = 1'b1;
        bus1.bin   = 8'd7;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (W1 + 3) @(negedge clk);

        // asynchronous reset in the middle of a conversion
        accept1(200);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(bus1.busy), 32'd0);
        check("rst_mid_done", 32'(bus1.done), 32'd0);
        check("rst_mid_bcd", 32'(bus1.bcd), 32'd0);
`ifdef BCD_XS3_OUT_EN
        check("rst_mid_xs3", 32'(bus1.xs3), 32'd0);
`endif
        sb1.delete();
        sb2.delete();
        last1 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run1(10, 1'b1);
        repeat (2) @(negedge clk);

        // back-to-back at the earliest legal accept
        run1(128, 1'b1);
        run1(64, 1'b1);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 256; i++) run1(i, 1'b0);

        for (int i = 0; i < 64; i++) begin
            v = int'($urandom_range(255, 0));
            accept1(v);
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(W1 - 1, 1)) @(negedge clk);
                bus1.start = 1'b1;
                bus1.bin   = W1'($urandom);
                @(negedge clk);
                bus1.start = 1'b0;
            end
            // leave the driver at least W1+1 negedges past accept
            repeat (W1 + 1) @(negedge clk);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
    endtask

    task automatic seq2();
        // hold off until the mid-run reset of dut1 is over so dut2's queue
        // is not flushed under it
        wait (cyc > 90 && rst_n === 1'b1);
        for (int i = 0; i < 16; i++) begin
            accept2(i);
            repeat (W2 + 1) @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            accept2(int'($urandom_range(15, 0)));
            repeat (W2 + 1 + $urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    initial begin
        bus1.start = 1'b0;
        bus1.bin   = '0;
        bus2.start = 1'b0;
        bus2.bin   = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus1.busy), 32'd0);
        check("reset_done", 32'(bus1.done), 32'd0);
        check("reset_bcd", 32'(bus1.bcd), 32'd0);
        check("reset_bcd_w4", 32'(bus2.bcd), 32'd0);
`ifdef BCD_XS3_OUT_EN
        check("reset_xs3", 32'(bus1.xs3), 32'd0);
`endif
        rst_n = 1'b1;

        fork
            seq1();
            seq2();
        join

        for (int i = 0; i < 50 && (sb1.size() != 0 || sb2.size() != 0); i++)
            @(negedge clk);
        check("drain_timeout", 32'(sb1.size() + sb2.size()), 32'd0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
